// File: rtl/vector_memory_sequencer_pkg.sv
// Shared CPU definitions for the vector memory sequencer: geometry, state encoding
// and the lane address helper.
package vector_memory_sequencer_pkg;

    localparam int unsigned VMS_LANES      = 16;
    localparam int unsigned VMS_LANE_WIDTH = 8;
    localparam int unsigned VMS_VEC_WIDTH  = 128;
    localparam int unsigned VMS_ADDR_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STORE     = 3'd1,
        LOAD      = 3'd2,
        LOAD_LAST = 3'd3,
        DONE      = 3'd4
    } vms_state_e;

    // Lane address wraps modulo the data-memory size.
    function automatic logic [VMS_ADDR_WIDTH-1:0] vms_lane_addr(
        input logic [VMS_ADDR_WIDTH-1:0] base,
        input logic [VMS_ADDR_WIDTH-1:0] offset
    );
        return base + offset;
    endfunction

endpackage

// File: rtl/vector_memory_sequencer.sv
// Sequences a 128-bit vector load/store as one data-memory access per lane while
// stalling the pipeline; scalar accesses pass straight through when idle.
module vector_memory_sequencer
    import vector_memory_sequencer_pkg::*;
#(
    parameter int unsigned LANES      = VMS_LANES,
    parameter int unsigned LANE_WIDTH = VMS_LANE_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_vector_load,
    input  logic                        start_vector_store,
    input  logic [VMS_ADDR_WIDTH-1:0]   base_address,
    input  logic [LANES*LANE_WIDTH-1:0] store_vector,
    input  logic [VMS_ADDR_WIDTH-1:0]   scalar_address,
    input  logic [LANE_WIDTH-1:0]       scalar_wdata,
    input  logic                        scalar_we,
    input  logic [LANE_WIDTH-1:0]       mem_rdata,
    output logic [VMS_ADDR_WIDTH-1:0]   mem_address,
    output logic [LANE_WIDTH-1:0]       mem_wdata,
    output logic                        mem_we,
    output logic                        stall,
    output logic [LANES*LANE_WIDTH-1:0] load_vector,
    output logic                        load_valid
);

    localparam int unsigned           CNT_WIDTH = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_WIDTH-1:0]  LAST_LANE = CNT_WIDTH'(LANES - 1);

    typedef logic [LANES-1:0][LANE_WIDTH-1:0] lanes_t;

    vms_state_e                r_state;
    logic [CNT_WIDTH-1:0]      r_count;
    logic [VMS_ADDR_WIDTH-1:0] r_base;
    lanes_t                    r_store_data;
    lanes_t                    r_load_buf;
    lanes_t                    r_load_vector;
    logic                      r_load_valid;

    logic                      w_start;
    logic [CNT_WIDTH-1:0]      w_prev_lane;
    logic [VMS_ADDR_WIDTH-1:0] w_lane_addr;
    lanes_t                    w_load_final;

    assign w_start     = start_vector_load | start_vector_store;
    assign w_prev_lane = r_count - CNT_WIDTH'(1);
    assign w_lane_addr = vms_lane_addr(r_base, VMS_ADDR_WIDTH'(r_count));

    // Read data trails the address by one cycle, so the final lane arrives in LOAD_LAST.
    always_comb begin
        w_load_final            = r_load_buf;
        w_load_final[LAST_LANE] = mem_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_base        <= '0;
            r_store_data  <= '0;
            r_load_buf    <= '0;
            r_load_vector <= '0;
            r_load_valid  <= 1'b0;
        end else begin
            r_load_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_count <= '0;
                    if (w_start) begin
                        r_base       <= base_address;
                        r_store_data <= store_vector;
                    end
                    if (start_vector_store) begin
                        r_state <= STORE;
                    end else if (start_vector_load) begin
                        r_state <= LOAD;
                    end
                end
                STORE: begin
                    r_count <= r_count + CNT_WIDTH'(1);
                    if (r_count == LAST_LANE) begin
                        r_state <= DONE;
                    end
                end
                LOAD: begin
                    if (r_count != '0) begin
                        r_load_buf[w_prev_lane] <= mem_rdata;
                    end
                    r_count <= r_count + CNT_WIDTH'(1);
                    if (r_count == LAST_LANE) begin
                        r_state <= LOAD_LAST;
                    end
                end
                LOAD_LAST: begin
                    r_load_vector <= w_load_final;
                    r_load_valid  <= 1'b1;
                    r_state       <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Memory port steering; reset forces the port quiet regardless of scalar inputs.
    always_comb begin
        mem_address = '0;
        mem_wdata   = '0;
        mem_we      = 1'b0;
        stall       = 1'b0;
        case (r_state)
            IDLE: begin
                mem_address = scalar_address;
                mem_wdata   = scalar_wdata;
                mem_we      = scalar_we;
                stall       = w_start;
            end
            STORE: begin
                mem_address = w_lane_addr;
                mem_wdata   = r_store_data[r_count];
                mem_we      = 1'b1;
                stall       = 1'b1;
            end
            LOAD, LOAD_LAST: begin
                mem_address = w_lane_addr;
                stall       = 1'b1;
            end
            DONE: begin
                mem_address = scalar_address;
                mem_wdata   = scalar_wdata;
                mem_we      = scalar_we;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
        if (reset) begin
            mem_address = '0;
            mem_wdata   = '0;
            mem_we      = 1'b0;
            stall       = 1'b0;
        end
    end

    assign load_vector = r_load_vector;
    assign load_valid  = r_load_valid;

endmodule

// File: doc/vector_memory_sequencer.md
VECTOR_MEMORY_SEQUENCER -- requirements
Module: vector_memory_sequencer

Interface
REQ-001 Parameter LANES, default 16, number of vector lanes per 128-bit vector.
REQ-002 Parameter LANE_WIDTH, default 8, bits per lane and data-memory word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start_vector_load  input  1  memory-stage instruction is a vector load.
REQ-006 start_vector_store  input  1  memory-stage instruction is a vector store.
REQ-007 base_address  input  8  vector base address, from ALU result in memory stage.
REQ-008 store_vector  input  128  vector store data; lane i = bits [8i+7:8i].
REQ-009 scalar_address  input  8  scalar access address, passed through when idle.
REQ-010 scalar_wdata  input  8  scalar store data, passed through when idle.
REQ-011 scalar_we  input  1  scalar write enable, passed through when idle.
REQ-012 mem_rdata  input  8  data-memory read data, valid one cycle after mem_address.
REQ-013 mem_address  output  8  data-memory address.
REQ-014 mem_wdata  output  8  data-memory write data.
REQ-015 mem_we  output  1  data-memory write enable.
REQ-016 stall  output  1  holds fetch through memory pipeline registers.
REQ-017 load_vector  output  128  assembled vector load result.
REQ-018 load_valid  output  1  one-cycle pulse, load_vector complete.

Function
REQ-019 States: IDLE, STORE, LOAD, LOAD_LAST, DONE; 4-bit lane counter; base_address and store_vector latched on start.
REQ-020 IDLE: start_vector_store -> STORE; else start_vector_load -> LOAD; store wins if both asserted; counter cleared.
REQ-021 stall = (IDLE and any start) or STORE or LOAD or LOAD_LAST; combinational; low in DONE and in IDLE without start.
REQ-022 IDLE and DONE: mem_address/mem_wdata/mem_we mirror scalar_address/scalar_wdata/scalar_we.
REQ-023 STORE: mem_we=1, mem_address=latched base+counter mod 256, mem_wdata=lane[counter]; counter+1; after counter 15 -> DONE.
REQ-024 LOAD: mem_we=0, mem_address=base+counter mod 256; for counter k>=1, mem_rdata written into lane k-1; after counter 15 -> LOAD_LAST.
REQ-025 LOAD_LAST: mem_we=0, mem_rdata written into lane 15 -> DONE.
REQ-026 DONE: load_valid=1 only when entered from LOAD_LAST; start inputs ignored; unconditionally -> IDLE.
REQ-027 Latency: store stalls 17 cycles (start + 16 writes) then DONE; load stalls 18 cycles then DONE with load_valid.
REQ-028 Starts while not IDLE are ignored; inputs may change mid-operation without effect (latched copies used).
REQ-029 load_vector holds its value until the next load completes.
REQ-030 Address wrap: base 0xF8 accesses 0xF8..0xFF then 0x00..0x07.

Reset
REQ-031 reset asynchronously forces IDLE, counter 0, latched base/data 0, load_vector 0, load_valid 0.
REQ-032 During reset mem_we=0, mem_address=0, mem_wdata=0, stall=0 regardless of scalar inputs.
REQ-033 Reset mid-operation aborts: lanes already written stay in memory, no load_valid pulse, no DONE.

Structure
REQ-034 Shared CPU package holds the state enum, LANES, LANE_WIDTH and vector width 128.
REQ-035 Single module; no sub-module required; data memory instantiated outside the block.

Verification
REQ-036 Store base 0x10, store_vector lane i = i+1 -> 16 writes 0x10..0x1F values 0x01..0x10, stall high 17 cycles, mem_we low in DONE.
REQ-037 Load base 0x10 after 036 -> load_vector lanes 0..15 = 0x01..0x10, load_valid single pulse 19th cycle after start, stall low that cycle.
REQ-038 Store base 0xF8 -> addresses 0xF8..0xFF, 0x00..0x07 in order.
REQ-039 Both starts asserted same cycle, base 0x20 -> store performed, no load_valid.
REQ-040 reset asserted at load counter 7 -> IDLE immediately, stall 0, load_vector 0, no load_valid.
REQ-041 Idle, scalar_we=1, scalar_address 0x05, scalar_wdata 0xAA -> mem_we=1, mem_address 0x05, mem_wdata 0xAA same cycle, stall 0.
